// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU memory path: store/load op codes and
// the store-unit FSM state type.
package mips_cpu_pkg;

    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SWL = 3'b110;
    localparam logic [2:0] OP_SWR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } store_state_t;

endpackage

// File: rtl/mips_cpu_store_formatter.sv
// Combinational little-endian lane formatter for SB/SH/SW/SWL/SWR stores;
// flags misaligned halfword/word stores and illegal op codes.
module mips_cpu_store_formatter
    import mips_cpu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [31:0] data,
    input  logic [2:0]  controls,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic        fault
);

    always_comb begin
        byteenable = 4'b0000;
        writedata  = data;
        fault      = 1'b0;
        case (controls)
            OP_SB: begin
                byteenable = 4'b0001 << off;
                writedata  = {4{data[7:0]}};
            end
            OP_SH: begin
                writedata = {2{data[15:0]}};
                case (off)
                    2'd0:    byteenable = 4'b0011;
                    2'd2:    byteenable = 4'b1100;
                    default: fault      = 1'b1;
                endcase
            end
            OP_SW: begin
                if (off == 2'd0) byteenable = 4'b1111;
                else             fault      = 1'b1;
            end
            // SWL writes the high-order bytes of rt into the lower lanes up to off
            OP_SWL: begin
                case (off)
                    2'd0: begin byteenable = 4'b0001; writedata = data >> 24; end
                    2'd1: begin byteenable = 4'b0011; writedata = data >> 16; end
                    2'd2: begin byteenable = 4'b0111; writedata = data >> 8;  end
                    default: begin byteenable = 4'b1111; writedata = data;    end
                endcase
            end
            OP_SWR: begin
                case (off)
                    2'd0: begin byteenable = 4'b1111; writedata = data;       end
                    2'd1: begin byteenable = 4'b1110; writedata = data << 8;  end
                    2'd2: begin byteenable = 4'b1100; writedata = data << 16; end
                    default: begin byteenable = 4'b1000; writedata = data << 24; end
                endcase
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_cpu_store_unit.sv
// Store unit: captures one store request, formats it, and issues a single
// Avalon-MM write with waitrequest handshaking; faulted requests skip the bus.
module mips_cpu_store_unit
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    input  logic [2:0]        controls,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic              waitrequest
);

    store_state_t state;
    logic [3:0]   fmt_byteenable;
    logic [31:0]  fmt_writedata;
    logic         fmt_fault;

    mips_cpu_store_formatter u_formatter (
        .off        (addr[1:0]),
        .data       (data),
        .controls   (controls),
        .byteenable (fmt_byteenable),
        .writedata  (fmt_writedata),
        .fault      (fmt_fault)
    );

    assign busy = (state != ST_IDLE);

    // Bus outputs are captured on acceptance so the request inputs may change freely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            write      <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            address    <= '0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        address    <= {addr[ADDR_W-1:2], 2'b00};
                        byteenable <= fmt_byteenable;
                        writedata  <= fmt_writedata;
                        fault      <= fmt_fault;
                        if (fmt_fault) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_WRITE;
                            write <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!waitrequest) begin
                        state <= ST_DONE;
                        write <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    write <= 1'b0;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_store_unit.sv
// Directed self-checking bench for mips_cpu_store_unit; inputs are driven and
// outputs checked on the falling clock edge.
module tb_mips_cpu_store_unit;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  controls;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] address;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;

    int checkCount  = 0;
    int passCount   = 0;
    int failCount   = 0;
    int writeCycles = 0;
    int doneCycles  = 0;
    int savedWrites;
    int savedDones;

    logic [3:0]  swlBe [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [31:0] swlWd [4] = '{32'h0000_0011, 32'h0000_1122, 32'h0011_2233, 32'h1122_3344};
    logic [3:0]  swrBe [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [31:0] swrWd [4] = '{32'h1122_3344, 32'h2233_4400, 32'h3344_0000, 32'h4400_0000};

    mips_cpu_store_unit #(.ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .addr        (addr),
        .data        (data),
        .controls    (controls),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .address     (address),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .waitrequest (waitrequest)
    );

    always #5 clk = ~clk;

    // Count write-high and done-high cycles as seen at each rising edge
    always @(posedge clk) begin
        if (write) writeCycles <= writeCycles + 1;
        if (done)  doneCycles  <= doneCycles + 1;
    end

    function automatic logic [31:0] laneMask(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkLanes(input string tag, input logic [3:0] expBe, input logic [31:0] expWd);
        checkOutput({tag, " byteenable"}, {28'h0, byteenable}, {28'h0, expBe});
        checkOutput({tag, " writedata"}, writedata & laneMask(expBe), expWd & laneMask(expBe));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " busy"},  {31'h0, busy},  32'h0);
        checkOutput({tag, " write"}, {31'h0, write}, 32'h0);
        checkOutput({tag, " done"},  {31'h0, done},  32'h0);
        checkOutput({tag, " fault"}, {31'h0, fault}, 32'h0);
    endtask

    // Presents a request for one cycle, then scrambles the inputs
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        addr     = a;
        data     = d;
        controls = c;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        addr     = 32'hFFFF_FFFF;
        data     = 32'h5A5A_5A5A;
        controls = 3'b011;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        waitrequest = 1'b0;
        addr        = 32'h0;
        data        = 32'h0;
        controls    = 3'b000;
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset address", address, 32'h0);
        checkOutput("reset byteenable", {28'h0, byteenable}, 32'h0);
        checkOutput("reset writedata", writedata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] SB zero-wait");
        applyStimulus(32'h0000_1003, 32'hAABB_CCDD, OP_SB);
        checkOutput("sb c1 write", {31'h0, write}, 32'h1);
        checkOutput("sb c1 busy", {31'h0, busy}, 32'h1);
        checkOutput("sb c1 done", {31'h0, done}, 32'h0);
        checkOutput("sb address", address, 32'h0000_1000);
        checkLanes("sb", 4'b1000, 32'hDD00_0000);
        @(negedge clk);
        checkOutput("sb c2 done", {31'h0, done}, 32'h1);
        checkOutput("sb c2 fault", {31'h0, fault}, 32'h0);
        checkOutput("sb c2 write", {31'h0, write}, 32'h0);
        checkOutput("sb c2 busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        checkIdleOutputs("sb c3");

        $display("[TB] SH with three wait cycles");
        waitrequest = 1'b1;
        applyStimulus(32'h0000_2002, 32'hAABB_CCDD, OP_SH);
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("sh c%0d write", c), {31'h0, write}, 32'h1);
            checkOutput($sformatf("sh c%0d address", c), address, 32'h0000_2000);
            checkLanes($sformatf("sh c%0d", c), 4'b1100, 32'hCCDD_0000);
            checkOutput($sformatf("sh c%0d done", c), {31'h0, done}, 32'h0);
            if (c == 4) waitrequest = 1'b0;
            @(negedge clk);
        end
        checkOutput("sh c5 done", {31'h0, done}, 32'h1);
        checkOutput("sh c5 write", {31'h0, write}, 32'h0);
        @(negedge clk);
        checkIdleOutputs("sh c6");

        $display("[TB] misaligned SW and illegal op");
        savedWrites = writeCycles;
        applyStimulus(32'h0000_3001, 32'h1234_5678, OP_SW);
        checkOutput("sw-misaligned done", {31'h0, done}, 32'h1);
        checkOutput("sw-misaligned fault", {31'h0, fault}, 32'h1);
        checkOutput("sw-misaligned write", {31'h0, write}, 32'h0);
        @(negedge clk);
        checkIdleOutputs("sw-misaligned c2");
        applyStimulus(32'h0000_3001, 32'h1234_5678, 3'b100);
        checkOutput("illegal done", {31'h0, done}, 32'h1);
        checkOutput("illegal fault", {31'h0, fault}, 32'h1);
        checkOutput("illegal write", {31'h0, write}, 32'h0);
        @(negedge clk);
        checkIdleOutputs("illegal c2");
        checkOutput("fault write count", writeCycles - savedWrites, 32'h0);

        $display("[TB] SWL/SWR offset sweep");
        for (int off = 0; off < 4; off++) begin
            applyStimulus(32'h0000_4000 + off, 32'h1122_3344, OP_SWL);
            checkOutput($sformatf("swl off%0d write", off), {31'h0, write}, 32'h1);
            checkLanes($sformatf("swl off%0d", off), swlBe[off], swlWd[off]);
            @(negedge clk);
            checkOutput($sformatf("swl off%0d done", off), {31'h0, done}, 32'h1);
            @(negedge clk);
            applyStimulus(32'h0000_4000 + off, 32'h1122_3344, OP_SWR);
            checkOutput($sformatf("swr off%0d address", off), address, 32'h0000_4000);
            checkLanes($sformatf("swr off%0d", off), swrBe[off], swrWd[off]);
            @(negedge clk);
            checkOutput($sformatf("swr off%0d done", off), {31'h0, done}, 32'h1);
            @(negedge clk);
        end

        $display("[TB] start ignored during WRITE, back-to-back accepted");
        savedWrites = writeCycles;
        savedDones  = doneCycles;
        waitrequest = 1'b1;
        applyStimulus(32'h0000_5000, 32'hDEAD_BEEF, OP_SW);
        addr     = 32'h0000_6000;
        data     = 32'h0000_0077;
        controls = OP_SB;
        start    = 1'b1;
        checkOutput("busy-start c1 write", {31'h0, write}, 32'h1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy-start c2 address", address, 32'h0000_5000);
        checkLanes("busy-start c2", 4'b1111, 32'hDEAD_BEEF);
        waitrequest = 1'b0;
        @(negedge clk);
        checkOutput("busy-start c3 done", {31'h0, done}, 32'h1);
        @(negedge clk);
        checkIdleOutputs("busy-start c4");
        checkOutput("busy-start done count", doneCycles - savedDones, 32'h1);
        checkOutput("busy-start write count", writeCycles - savedWrites, 32'h2);
        applyStimulus(32'h0000_6001, 32'h0000_0055, OP_SB);
        checkOutput("b2b write", {31'h0, write}, 32'h1);
        checkOutput("b2b address", address, 32'h0000_6000);
        checkLanes("b2b", 4'b0010, 32'h0000_5500);
        @(negedge clk);
        checkOutput("b2b done", {31'h0, done}, 32'h1);
        @(negedge clk);

        $display("[TB] reset during WRITE");
        waitrequest = 1'b1;
        applyStimulus(32'h0000_7000, 32'hCAFE_F00D, OP_SW);
        checkOutput("rst-mid c1 write", {31'h0, write}, 32'h1);
        savedDones = doneCycles;
        reset = 1'b1;
        #1;
        checkIdleOutputs("rst-mid async");
        checkOutput("rst-mid address", address, 32'h0);
        checkOutput("rst-mid byteenable", {28'h0, byteenable}, 32'h0);
        checkOutput("rst-mid writedata", writedata, 32'h0);
        @(negedge clk);
        reset       = 1'b0;
        waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("rst-mid after");
        checkOutput("rst-mid done count", doneCycles - savedDones, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
